// File: rtl/ixc_gfifo_port_mc.sv
// ixc_gfifo_port_mc
// Multi-channel GFIFO port. Toggle-encoded channel requests are granted
// round-robin into a small local buffer. The buffer drains onto the shared GF
// bus while the token chain is free and the collector is not back-pressuring.

module ixc_gfifo_port_mc #(
    parameter int NCH   = 4,
    parameter int DW    = 32,
    parameter int CBW   = 20,
    parameter int LENW  = 12,
    parameter int GFW   = 512,
    parameter int DEPTH = 4
) (
    input  logic                     fclk,
    input  logic                     rst_n,
    input  logic [NCH-1:0]           ch_req,
    input  logic [NCH*CBW-1:0]       ch_cbid,
    input  logic [NCH*LENW-1:0]      ch_len,
    input  logic [NCH*DW-1:0]        ch_data,
    output logic [NCH-1:0]           ch_ack,
    input  logic                     gf_lock,
    input  logic                     tkin,
    output logic                     tkout,
    input  logic                     gf_full,
    output logic                     gf_req,
    output logic [CBW-1:0]           gf_cbid,
    output logic [LENW-1:0]          gf_len,
    output logic [GFW-1:0]           gf_data,
    output logic                     lb_full,
    output logic [$clog2(DEPTH):0]   lb_count,
    output logic                     stall_err
);

    localparam int AW  = $clog2(DEPTH);
    localparam int RRW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int EW  = CBW + LENW + DW;
    localparam logic [AW:0]    LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [RRW-1:0] LP_LAST  = RRW'(NCH - 1);

    // Buffer entry layout: {cbid, len, data}
    logic [EW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic [RRW-1:0]   r_rr;
    logic [NCH-1:0]   r_ack;
    logic             r_gf_req;
    logic [CBW-1:0]   r_gf_cbid;
    logic [LENW-1:0]  r_gf_len;
    logic [GFW-1:0]   r_gf_data;
    logic             r_lb_full;
    logic             r_stall;

    logic [NCH-1:0]   w_pend;
    logic             w_any;
    logic             w_enq;
    logic             w_deq;
    logic             w_found;
    logic             w_take;
    logic [NCH-1:0]   w_gnt_oh;
    logic [RRW-1:0]   w_gnt;
    logic [EW-1:0]    w_gnt_entry;
    logic [EW-1:0]    w_rd_entry;
    logic [AW:0]      w_count_nxt;
    logic [RRW-1:0]   w_rr_nxt;

    assign w_pend     = ch_req ^ r_ack;
    assign w_any      = |w_pend;
    assign w_enq      = !gf_lock && (r_count < LP_DEPTH) && w_any;
    assign w_deq      = !gf_lock && !tkin && !gf_full && (r_count != '0);
    assign w_rd_entry = r_mem[r_rd];

    // Round-robin pick: first pending channel at or after r_rr, then wrap to the low channels
    always_comb begin
        w_found     = 1'b0;
        w_take      = 1'b0;
        w_gnt_oh    = '0;
        w_gnt       = '0;
        w_gnt_entry = '0;
        for (int i = 0; i < NCH; i++) begin
            w_take      = !w_found && w_pend[i] && (i >= int'(r_rr));
            w_gnt_oh[i] = w_gnt_oh[i] | w_take;
            w_gnt       = w_gnt | (w_take ? RRW'(i) : RRW'(0));
            w_gnt_entry = w_gnt_entry | ({EW{w_take}} &
                          {ch_cbid[i*CBW +: CBW], ch_len[i*LENW +: LENW], ch_data[i*DW +: DW]});
            w_found     = w_found | w_take;
        end
        for (int i = 0; i < NCH; i++) begin
            w_take      = !w_found && w_pend[i];
            w_gnt_oh[i] = w_gnt_oh[i] | w_take;
            w_gnt       = w_gnt | (w_take ? RRW'(i) : RRW'(0));
            w_gnt_entry = w_gnt_entry | ({EW{w_take}} &
                          {ch_cbid[i*CBW +: CBW], ch_len[i*LENW +: LENW], ch_data[i*DW +: DW]});
            w_found     = w_found | w_take;
        end
    end

    // Next occupancy and next round-robin start point
    always_comb begin
        w_count_nxt = r_count;
        case ({w_enq, w_deq})
            2'b10:   w_count_nxt = r_count + (AW+1)'(1);
            2'b01:   w_count_nxt = r_count - (AW+1)'(1);
            default: w_count_nxt = r_count;
        endcase
        if (w_gnt == LP_LAST) begin
            w_rr_nxt = '0;
        end else begin
            w_rr_nxt = w_gnt + RRW'(1);
        end
    end

    // Enqueue side: store the granted request, toggle its ack, advance the rr pointer
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr  <= '0;
            r_rr  <= '0;
            r_ack <= '0;
        end else if (w_enq) begin
            r_mem[r_wr] <= w_gnt_entry;
            r_wr        <= r_wr + AW'(1);
            r_rr        <= w_rr_nxt;
            r_ack       <= r_ack ^ w_gnt_oh;
        end
    end

    // Dequeue side: present the head entry on the GF bus for one cycle, otherwise hold
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd      <= '0;
            r_gf_req  <= 1'b0;
            r_gf_cbid <= '0;
            r_gf_len  <= '0;
            r_gf_data <= '0;
        end else if (w_deq) begin
            r_rd      <= r_rd + AW'(1);
            r_gf_req  <= 1'b1;
            r_gf_cbid <= w_rd_entry[DW+LENW +: CBW];
            r_gf_len  <= w_rd_entry[DW +: LENW];
            r_gf_data <= GFW'(w_rd_entry[DW-1:0]);
        end else begin
            r_gf_req  <= 1'b0;
        end
    end

    // Occupancy, full flag and sticky stall indication
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_lb_full <= 1'b0;
            r_stall   <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_lb_full <= (w_count_nxt == LP_DEPTH);
            if (r_lb_full && w_any && !gf_lock) begin
                r_stall <= 1'b1;
            end
        end
    end

    // The token passes downstream as soon as this port has anything to send
    assign tkout     = tkin | (r_count != '0);
    assign ch_ack    = r_ack;
    assign gf_req    = r_gf_req;
    assign gf_cbid   = r_gf_cbid;
    assign gf_len    = r_gf_len;
    assign gf_data   = r_gf_data;
    assign lb_full   = r_lb_full;
    assign lb_count  = r_count;
    assign stall_err = r_stall;

endmodule

// File: tb/tb_ixc_gfifo_port_mc.sv
// Directed testbench for ixc_gfifo_port_mc (NCH=4, DEPTH=4).

module tb_ixc_gfifo_port_mc;

    localparam int NCH   = 4;
    localparam int DW    = 32;
    localparam int CBW   = 20;
    localparam int LENW  = 12;
    localparam int GFW   = 512;
    localparam int DEPTH = 4;

    logic                 fclk;
    logic                 rst_n;
    logic [NCH-1:0]       ch_req;
    logic [NCH*CBW-1:0]   ch_cbid;
    logic [NCH*LENW-1:0]  ch_len;
    logic [NCH*DW-1:0]    ch_data;
    logic [NCH-1:0]       ch_ack;
    logic                 gf_lock;
    logic                 tkin;
    logic                 tkout;
    logic                 gf_full;
    logic                 gf_req;
    logic [CBW-1:0]       gf_cbid;
    logic [LENW-1:0]      gf_len;
    logic [GFW-1:0]       gf_data;
    logic                 lb_full;
    logic [2:0]           lb_count;
    logic                 stall_err;

    int n_checks;
    int n_errors;

    ixc_gfifo_port_mc #(
        .NCH(NCH), .DW(DW), .CBW(CBW), .LENW(LENW), .GFW(GFW), .DEPTH(DEPTH)
    ) dut (
        .fclk(fclk), .rst_n(rst_n), .ch_req(ch_req), .ch_cbid(ch_cbid),
        .ch_len(ch_len), .ch_data(ch_data), .ch_ack(ch_ack), .gf_lock(gf_lock),
        .tkin(tkin), .tkout(tkout), .gf_full(gf_full), .gf_req(gf_req),
        .gf_cbid(gf_cbid), .gf_len(gf_len), .gf_data(gf_data), .lb_full(lb_full),
        .lb_count(lb_count), .stall_err(stall_err)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [CBW-1:0] c, input logic [LENW-1:0] l,
                          input logic [DW-1:0] d);
        ch_cbid[i*CBW +: CBW]   = c;
        ch_len[i*LENW +: LENW]  = l;
        ch_data[i*DW +: DW]     = d;
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        ch_req  = '0;
        ch_cbid = '0;
        ch_len  = '0;
        ch_data = '0;
        gf_lock = 1'b0;
        tkin    = 1'b0;
        gf_full = 1'b0;
        repeat (2) @(posedge fclk);
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (ch_ack !== 4'h0) begin n_errors++; $display("FAIL rst_ack: got %h want 0", ch_ack); end
        n_checks++;
        if ({gf_req, gf_cbid, gf_len} !== {1'b0, 20'h0, 12'h0}) begin
            n_errors++; $display("FAIL rst_gf: req %b cbid %h len %h want 0", gf_req, gf_cbid, gf_len);
        end
        n_checks++;
        if (gf_data !== '0) begin n_errors++; $display("FAIL rst_data: got %h want 0", gf_data); end
        n_checks++;
        if ({lb_full, lb_count, stall_err, tkout} !== 6'b0) begin
            n_errors++;
            $display("FAIL rst_status: full %b count %0d stall %b tkout %b want 0", lb_full, lb_count, stall_err, tkout);
        end
    endtask

    task automatic test_single();
        logic [GFW-1:0] exp_d;
        exp_d = GFW'(32'h0000_1234);
        set_ch(2, 20'h00ABC, 12'd8, 32'h0000_1234);
        ch_req[2] = ~ch_req[2];
        tick();
        n_checks++;
        if ({ch_ack, gf_req, lb_count, tkout} !== {4'b0100, 1'b0, 3'd1, 1'b1}) begin
            n_errors++;
            $display("FAIL t1_enq: ack %b req %b count %0d tkout %b want 0100 0 1 1", ch_ack, gf_req, lb_count, tkout);
        end
        tick();
        n_checks++;
        if ({gf_req, gf_cbid, gf_len} !== {1'b1, 20'h00ABC, 12'd8}) begin
            n_errors++; $display("FAIL t1_deq: req %b cbid %h len %0d want 1 00abc 8", gf_req, gf_cbid, gf_len);
        end
        n_checks++;
        if (gf_data !== exp_d) begin n_errors++; $display("FAIL t1_data: got %h want %h", gf_data, exp_d); end
        n_checks++;
        if (lb_count !== 3'd0) begin n_errors++; $display("FAIL t1_count: got %0d want 0", lb_count); end
        tick();
        n_checks++;
        if ({gf_req, gf_cbid, tkout} !== {1'b0, 20'h00ABC, 1'b0}) begin
            n_errors++; $display("FAIL t1_hold: req %b cbid %h tkout %b want 0 00abc 0", gf_req, gf_cbid, tkout);
        end
    endtask

    task automatic test_fairness();
        logic [NCH-1:0] exp_ack;
        apply_reset();
        for (int i = 0; i < NCH; i++) begin
            set_ch(i, 20'h00100 + 20'(i), 12'(i + 1), 32'h0000_A000 + 32'(i));
        end
        ch_req = 4'hF;
        for (int j = 1; j <= 5; j++) begin
            tick();
            if (j <= 4) begin
                exp_ack = 4'((1 << j) - 1);
                n_checks++;
                if (ch_ack !== exp_ack) begin
                    n_errors++; $display("FAIL t2_ack%0d: got %b want %b", j, ch_ack, exp_ack);
                end
            end
            n_checks++;
            if (j == 1) begin
                if (gf_req !== 1'b0) begin n_errors++; $display("FAIL t2_first: gf_req %b want 0", gf_req); end
            end else begin
                if ({gf_req, gf_cbid, gf_len} !== {1'b1, 20'h00100 + 20'(j - 2), 12'(j - 1)}) begin
                    n_errors++;
                    $display("FAIL t2_order%0d: req %b cbid %h len %0d want 1 %h %0d", j, gf_req, gf_cbid, gf_len,
                             20'h00100 + 20'(j - 2), j - 1);
                end
            end
        end
        tick();
        n_checks++;
        if ({gf_req, lb_count} !== {1'b0, 3'd0}) begin
            n_errors++; $display("FAIL t2_end: req %b count %0d want 0 0", gf_req, lb_count);
        end
    endtask

    task automatic test_full();
        logic [CBW-1:0] exp_c [6];
        exp_c[0] = 20'h00100; exp_c[1] = 20'h00101; exp_c[2] = 20'h00102;
        exp_c[3] = 20'h00103; exp_c[4] = 20'h00200; exp_c[5] = 20'h00201;
        apply_reset();
        gf_full = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            set_ch(i, 20'h00100 + 20'(i), 12'(i + 1), 32'h0000_B000 + 32'(i));
        end
        ch_req = 4'hF;
        repeat (4) tick();
        n_checks++;
        if ({lb_count, lb_full, ch_ack, gf_req, stall_err} !== {3'd4, 1'b1, 4'hF, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL t3_fill: count %0d full %b ack %b req %b stall %b want 4 1 1111 0 0",
                     lb_count, lb_full, ch_ack, gf_req, stall_err);
        end
        set_ch(0, 20'h00200, 12'd5, 32'h0000_B100);
        set_ch(1, 20'h00201, 12'd6, 32'h0000_B101);
        ch_req = 4'b1100;
        tick();
        n_checks++;
        if ({stall_err, lb_count, ch_ack} !== {1'b1, 3'd4, 4'hF}) begin
            n_errors++;
            $display("FAIL t3_stall: stall %b count %0d ack %b want 1 4 1111", stall_err, lb_count, ch_ack);
        end
        gf_full = 1'b0;
        for (int j = 0; j < 6; j++) begin
            tick();
            n_checks++;
            if ({gf_req, gf_cbid} !== {1'b1, exp_c[j]}) begin
                n_errors++; $display("FAIL t3_drain%0d: req %b cbid %h want 1 %h", j, gf_req, gf_cbid, exp_c[j]);
            end
            if (j == 0) begin
                n_checks++;
                if ({lb_count, lb_full, ch_ack} !== {3'd3, 1'b0, 4'hF}) begin
                    n_errors++;
                    $display("FAIL t3_bubble: count %0d full %b ack %b want 3 0 1111", lb_count, lb_full, ch_ack);
                end
            end
            if (j == 2) begin
                n_checks++;
                if ({lb_count, ch_ack} !== {3'd3, 4'b1100}) begin
                    n_errors++; $display("FAIL t3_regrant: count %0d ack %b want 3 1100", lb_count, ch_ack);
                end
            end
        end
        tick();
        n_checks++;
        if ({gf_req, lb_count, lb_full, stall_err} !== {1'b0, 3'd0, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL t3_end: req %b count %0d full %b stall %b want 0 0 0 1", gf_req, lb_count, lb_full, stall_err);
        end
    endtask

    task automatic test_token();
        apply_reset();
        tkin = 1'b1;
        #1;
        n_checks++;
        if (tkout !== 1'b1) begin n_errors++; $display("FAIL t4_pass: tkout %b want 1", tkout); end
        set_ch(0, 20'h00400, 12'd1, 32'h0000_0400);
        set_ch(1, 20'h00401, 12'd2, 32'h0000_0401);
        ch_req = 4'b0011;
        for (int j = 0; j < 4; j++) begin
            tick();
            n_checks++;
            if (gf_req !== 1'b0) begin n_errors++; $display("FAIL t4_block%0d: gf_req %b want 0", j, gf_req); end
        end
        tkin = 1'b0;
        #1;
        n_checks++;
        if ({lb_count, tkout} !== {3'd2, 1'b1}) begin
            n_errors++; $display("FAIL t4_held: count %0d tkout %b want 2 1", lb_count, tkout);
        end
        tick();
        n_checks++;
        if ({gf_req, gf_cbid} !== {1'b1, 20'h00400}) begin
            n_errors++; $display("FAIL t4_first: req %b cbid %h want 1 00400", gf_req, gf_cbid);
        end
        tick();
        n_checks++;
        if ({gf_req, gf_cbid} !== {1'b1, 20'h00401}) begin
            n_errors++; $display("FAIL t4_second: req %b cbid %h want 1 00401", gf_req, gf_cbid);
        end
        tick();
        n_checks++;
        if ({gf_req, tkout} !== {1'b0, 1'b0}) begin
            n_errors++; $display("FAIL t4_done: req %b tkout %b want 0 0", gf_req, tkout);
        end
    endtask

    task automatic test_lock_reset();
        apply_reset();
        gf_lock = 1'b1;
        set_ch(0, 20'h00500, 12'd3, 32'h0000_0500);
        ch_req = 4'b0001;
        for (int j = 0; j < 3; j++) begin
            tick();
            n_checks++;
            if ({ch_ack, gf_req, lb_count, stall_err} !== {4'h0, 1'b0, 3'd0, 1'b0}) begin
                n_errors++;
                $display("FAIL t5_lock%0d: ack %b req %b count %0d stall %b want 0 0 0 0", j, ch_ack, gf_req, lb_count, stall_err);
            end
        end
        gf_lock = 1'b0;
        gf_full = 1'b1;
        tick();
        n_checks++;
        if ({ch_ack, lb_count} !== {4'b0001, 3'd1}) begin
            n_errors++; $display("FAIL t5_unlock: ack %b count %0d want 0001 1", ch_ack, lb_count);
        end
        set_ch(1, 20'h00501, 12'd4, 32'h0000_0501);
        set_ch(2, 20'h00502, 12'd5, 32'h0000_0502);
        ch_req = 4'b0111;
        repeat (2) tick();
        gf_full = 1'b0;
        gf_lock = 1'b1;
        tick();
        n_checks++;
        if ({gf_req, lb_count, ch_ack} !== {1'b0, 3'd3, 4'b0111}) begin
            n_errors++; $display("FAIL t5_lockdeq: req %b count %0d ack %b want 0 3 0111", gf_req, lb_count, ch_ack);
        end
        gf_lock = 1'b0;
        tick();
        n_checks++;
        if ({gf_req, gf_cbid, lb_count} !== {1'b1, 20'h00500, 3'd2}) begin
            n_errors++; $display("FAIL t5_drain: req %b cbid %h count %0d want 1 00500 2", gf_req, gf_cbid, lb_count);
        end
        #2;
        rst_n  = 1'b0;
        ch_req = '0;
        #1;
        n_checks++;
        if ({ch_ack, gf_req, gf_cbid, gf_len, lb_count, lb_full, stall_err, tkout} !== 43'h0) begin
            n_errors++;
            $display("FAIL t5_async: ack %b req %b cbid %h len %h count %0d full %b stall %b tkout %b want all 0",
                     ch_ack, gf_req, gf_cbid, gf_len, lb_count, lb_full, stall_err, tkout);
        end
        n_checks++;
        if (gf_data !== '0) begin n_errors++; $display("FAIL t5_async_data: got %h want 0", gf_data); end
        @(posedge fclk);
        #3;
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({lb_count, gf_req, ch_ack} !== {3'd0, 1'b0, 4'h0}) begin
            n_errors++; $display("FAIL t5_after: count %0d req %b ack %b want 0 0 0", lb_count, gf_req, ch_ack);
        end
    endtask

    task automatic test_wrap();
        logic [CBW-1:0]  exp_q [$];
        logic [CBW-1:0]  exp_c;
        logic [LENW-1:0] exp_l;
        int sent;
        int cur_ch;
        bit waiting;
        int total;
        total   = 3 * DEPTH + 1;
        sent    = 0;
        cur_ch  = 0;
        waiting = 1'b0;
        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!waiting && sent < total) begin
                cur_ch = sent % NCH;
                set_ch(cur_ch, 20'h00300 + 20'(sent), 12'(sent + 16), 32'h0000_C000 + 32'(sent));
                ch_req[cur_ch] = ~ch_req[cur_ch];
                exp_q.push_back(20'h00300 + 20'(sent));
                waiting = 1'b1;
            end
            gf_full = (sent < total) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            if (gf_req === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++; $display("FAIL t6_extra: unexpected gf_req cbid %h", gf_cbid);
                end else begin
                    exp_c = exp_q.pop_front();
                    exp_l = 12'(exp_c - 20'h00300 + 20'd16);
                    if ({gf_cbid, gf_len, gf_data[DW-1:0]} !== {exp_c, exp_l, 32'h0000_C000 + 32'(exp_c - 20'h00300)}) begin
                        n_errors++;
                        $display("FAIL t6_order: cbid %h len %0d data %h want %h %0d", gf_cbid, gf_len,
                                 gf_data[DW-1:0], exp_c, exp_l);
                    end
                end
            end
            if (waiting && (ch_ack[cur_ch] === ch_req[cur_ch])) begin
                waiting = 1'b0;
                sent++;
            end
            if (sent == total && exp_q.size() == 0) break;
        end
        n_checks++;
        if (sent != total || exp_q.size() != 0) begin
            n_errors++; $display("FAIL t6_budget: sent %0d left %0d want %0d 0", sent, exp_q.size(), total);
        end
        tick();
        n_checks++;
        if ({gf_req, lb_count, ch_ack} !== {1'b0, 3'd0, ch_req}) begin
            n_errors++; $display("FAIL t6_end: req %b count %0d ack %b want 0 0 %b", gf_req, lb_count, ch_ack, ch_req);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_single();
        test_fairness();
        test_full();
        test_token();
        test_lock_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
